imc22_uart_loader: RTL

IMC22_UART_LOADER -- requirements
Module: imc22_uart_loader

---
 rtl/imc22_uart_loader.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/imc22_uart_loader.sv
// UART-driven loader for the NPU: receives 8N1 bytes and parses them into SRAM
// bursts, config register writes and NPU start/done handshakes.
module imc22_uart_loader #(
    parameter int CLKS_PER_BIT = 868,
    parameter int TIMEOUT_CLKS = 1000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        uart_rx,
    output logic        sram_we,
    output logic [9:0]  sram_waddr,
    output logic [7:0]  sram_wdata,
    output logic        npu_cfg_wr,
    output logic [7:0]  npu_cfg_addr,
    output logic [31:0] npu_cfg_wdata,
    output logic        npu_start,
    input  logic        npu_done,
    output logic        busy,
    output logic        err_frame,
    output logic        err_cmd,
    output logic        err_timeout
);

    localparam logic [15:0] BIT_LOAD  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LOAD = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [31:0] TO_LOAD   = 32'(TIMEOUT_CLKS - 1);

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_t;
    typedef enum logic [2:0] {IDLE, S_AH, S_AL, S_LEN, S_DATA, C_ADDR, C_DATA, WAIT_DONE} state_t;

    logic [1:0]  sync;
    logic        rx_s;
    logic        rx_prev;
    rx_state_t   rx_state;
    logic [15:0] bit_cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  rx_shift;
    logic [7:0]  rx_byte;
    logic        byte_valid;

    assign rx_s = sync[1];

    // Receiver: every sample point is a down-count to zero from the last one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync       <= 2'b11;
            rx_prev    <= 1'b1;
            rx_state   <= RX_IDLE;
            bit_cnt    <= '0;
            bit_idx    <= '0;
            rx_shift   <= '0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
            err_frame  <= 1'b0;
        end else begin
            sync       <= {sync[0], uart_rx};
            rx_prev    <= rx_s;
            byte_valid <= 1'b0;
            err_frame  <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (rx_prev && !rx_s) begin
                        rx_state <= RX_START;
                        bit_cnt  <= HALF_LOAD;
                    end
                end
                RX_START: begin
                    if (bit_cnt != 16'd0) begin
                        bit_cnt <= bit_cnt - 16'd1;
                    end else if (rx_s) begin
                        rx_state <= RX_IDLE;
                    end else begin
                        rx_state <= RX_DATA;
                        bit_cnt  <= BIT_LOAD;
                        bit_idx  <= '0;
                    end
                end
                RX_DATA: begin
                    if (bit_cnt != 16'd0) begin
                        bit_cnt <= bit_cnt - 16'd1;
                    end else begin
                        rx_shift <= {rx_s, rx_shift[7:1]};
                        bit_cnt  <= BIT_LOAD;
                        if (bit_idx == 3'd7) rx_state <= RX_STOP;
                        else                 bit_idx  <= bit_idx + 3'd1;
                    end
                end
                RX_STOP: begin
                    if (bit_cnt != 16'd0) begin
                        bit_cnt <= bit_cnt - 16'd1;
                    end else if (rx_s) begin
                        byte_valid <= 1'b1;
                        rx_byte    <= rx_shift;
                        rx_state   <= RX_IDLE;
                    end else begin
                        err_frame <= 1'b1;
                        rx_state  <= RX_WAIT_HIGH;
                    end
                end
                RX_WAIT_HIGH: begin
                    if (rx_s) rx_state <= RX_IDLE;
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    state_t      state;
    logic [9:0]  addr;
    logic [8:0]  remaining;
    logic [7:0]  cfg_addr_r;
    logic [31:0] cfg_shift;
    logic [1:0]  cfg_cnt;
    logic [31:0] to_cnt;

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            addr          <= '0;
            remaining     <= '0;
            cfg_addr_r    <= '0;
            cfg_shift     <= '0;
            cfg_cnt       <= '0;
            to_cnt        <= '0;
            sram_we       <= 1'b0;
            sram_waddr    <= '0;
            sram_wdata    <= '0;
            npu_cfg_wr    <= 1'b0;
            npu_cfg_addr  <= '0;
            npu_cfg_wdata <= '0;
            npu_start     <= 1'b0;
            err_cmd       <= 1'b0;
            err_timeout   <= 1'b0;
        end else begin
            sram_we     <= 1'b0;
            npu_cfg_wr  <= 1'b0;
            npu_start   <= 1'b0;
            err_cmd     <= 1'b0;
            err_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (byte_valid) begin
                        case (rx_byte)
                            8'hA5: begin state <= S_AH;   to_cnt <= TO_LOAD; end
                            8'h5A: begin state <= C_ADDR; to_cnt <= TO_LOAD; end
                            8'h3C: begin state <= WAIT_DONE; npu_start <= 1'b1; end
                            default: err_cmd <= 1'b1;
                        endcase
                    end
                end
                WAIT_DONE: begin
                    if (npu_done)        state   <= IDLE;
                    else if (byte_valid) err_cmd <= 1'b1;
                end
                default: begin
                    // Packet states: each byte re-arms the inter-byte timeout.
                    if (byte_valid) begin
                        to_cnt <= TO_LOAD;
                        case (state)
                            S_AH: begin addr[9:8] <= rx_byte[1:0]; state <= S_AL; end
                            S_AL: begin addr[7:0] <= rx_byte;      state <= S_LEN; end
                            S_LEN: begin
                                remaining <= (rx_byte == 8'd0) ? 9'd256 : {1'b0, rx_byte};
                                state     <= S_DATA;
                            end
                            S_DATA: begin
                                sram_we    <= 1'b1;
                                sram_waddr <= addr;
                                sram_wdata <= rx_byte;
                                addr       <= addr + 10'd1;
                                remaining  <= remaining - 9'd1;
                                if (remaining == 9'd1) state <= IDLE;
                            end
                            C_ADDR: begin
                                cfg_addr_r <= rx_byte;
                                cfg_cnt    <= '0;
                                state      <= C_DATA;
                            end
                            C_DATA: begin
                                cfg_shift <= {rx_byte, cfg_shift[31:8]};
                                cfg_cnt   <= cfg_cnt + 2'd1;
                                if (cfg_cnt == 2'd3) begin
                                    npu_cfg_wr    <= 1'b1;
                                    npu_cfg_addr  <= cfg_addr_r;
                                    npu_cfg_wdata <= {rx_byte, cfg_shift[31:8]};
                                    state         <= IDLE;
                                end
                            end
                            default: state <= IDLE;
                        endcase
                    end else if (to_cnt == 32'd0) begin
                        err_timeout <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        to_cnt <= to_cnt - 32'd1;
                    end
                end
            endcase
        end
    end

endmodule
